frame_scrambler: RTL

FRAME_SCRAMBLER -- requirements
Module: frame_scrambler

---
 rtl/frame_scrambler_pkg.sv | 21 ++
 rtl/scrambler_lfsr.sv | 27 ++
 rtl/frame_scrambler.sv | 134 +++++++++++++
 3 files changed

// File: rtl/frame_scrambler_pkg.sv
// Shared types and constants for the frame scrambler (x^7+x^4+1 frame bit scrambler).
package frame_scrambler_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SERVICE = 3'd1,
    DATA    = 3'd2,
    TAIL    = 3'd3,
    PAD     = 3'd4
  } state_e;

  localparam int         SERVICE_BITS = 16;
  localparam int         TAIL_BITS    = 6;
  localparam logic [6:0] DEFAULT_SEED = 7'h7F;

  // An all-zero seed would lock the LFSR at zero forever.
  function automatic logic [6:0] fix_seed(input logic [6:0] seed);
    return (seed == 7'd0) ? DEFAULT_SEED : seed;
  endfunction

endpackage

// File: rtl/scrambler_lfsr.sv
// 7-bit scrambler state, x[7:1] = (x7..x1); S = x7 ^ x4, shifted in at x1 on advance.
module scrambler_lfsr
  import frame_scrambler_pkg::*;
(
  input  logic       Clock,
  input  logic       Reset,
  input  logic       load,
  input  logic [6:0] seed,
  input  logic       advance,
  output logic       s
);

  logic [7:1] x;

  assign s = x[7] ^ x[4];

  always_ff @(posedge Clock) begin
    if (Reset) begin
      x <= DEFAULT_SEED;
    end else if (load) begin
      x <= seed;
    end else if (advance) begin
      x <= {x[6:1], s};
    end
  end

endmodule

// File: rtl/frame_scrambler.sv
// Frame scrambler: SERVICE / DATA / TAIL / PAD bit framing with x^7+x^4+1 scrambling.
// Build option: FRAME_SCRAMBLER_TAIL_ZERO_EN forces the 6 tail outputs to 0.
module frame_scrambler
  import frame_scrambler_pkg::*;
(
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Start,
  input  logic [6:0]  Seed,
  input  logic [15:0] DataBits,
  input  logic [8:0]  PadBits,
  input  logic        Input,
  input  logic        InValid,
  output logic        InReady,
  output logic        Output,
  output logic        OutValid,
  input  logic        OutReady,
  output logic        Busy,
  output logic        Done,
  output state_e      dbg_state
);

  // Handshake: a bit moves when valid && ready are both high at a rising edge;
  // valid never waits on ready. In DATA the path is a pure pass-through, so
  // OutValid follows InValid and InReady follows OutReady combinationally.

  state_e      state, state_n;
  logic [15:0] cnt;
  logic [15:0] len;
  logic [15:0] data_bits;
  logic [8:0]  pad_bits;
  logic        done_q;
  logic        valid_raw;
  logic        ready_raw;
  logic        bit_b;
  logic        s;
  logic        xfer;
  logic        last;
  logic        start_ok;

  assign dbg_state = state;
  assign start_ok  = (state == IDLE) && Start;
  assign xfer      = OutValid && OutReady;
  assign last      = (cnt == (len - 16'd1));

  scrambler_lfsr u_lfsr (
    .Clock   (Clock),
    .Reset   (Reset),
    .load    (start_ok),
    .seed    (fix_seed(Seed)),
    .advance (xfer),
    .s       (s)
  );

  always_comb begin : out_decode
    valid_raw = 1'b0;
    ready_raw = 1'b0;
    bit_b     = 1'b0;
    len       = 16'd0;
    unique case (state)
      SERVICE: begin
        valid_raw = 1'b1;
        len       = 16'(SERVICE_BITS);
      end
      DATA: begin
        valid_raw = InValid;
        ready_raw = OutReady;
        bit_b     = Input;
        len       = data_bits;
      end
      TAIL: begin
        valid_raw = 1'b1;
        len       = 16'(TAIL_BITS);
      end
      PAD: begin
        valid_raw = 1'b1;
        len       = {7'd0, pad_bits};
      end
      default: ;
    endcase
  end

  // Reset masks every output combinationally so nothing leaks during the reset cycle.
  assign OutValid = valid_raw && !Reset;
  assign InReady  = ready_raw && !Reset;
  assign Busy     = (state != IDLE) && !Reset;
  assign Done     = done_q && !Reset;

`ifdef FRAME_SCRAMBLER_TAIL_ZERO_EN
  assign Output = Busy && (state != TAIL) && (s ^ bit_b);
`else
  assign Output = Busy && (s ^ bit_b);
`endif

  always_comb begin : next_state
    state_n = state;
    unique case (state)
      IDLE:    if (Start)        state_n = SERVICE;
      SERVICE: if (xfer && last) state_n = (data_bits == 16'd0) ? TAIL : DATA;
      DATA:    if (xfer && last) state_n = TAIL;
      TAIL:    if (xfer && last) state_n = (pad_bits == 9'd0) ? IDLE : PAD;
      PAD:     if (xfer && last) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Counter restarts at every phase boundary, so it only ever spans one phase.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      cnt       <= 16'd0;
      data_bits <= 16'd0;
      pad_bits  <= 9'd0;
      done_q    <= 1'b0;
    end else begin
      done_q <= xfer && last && (state_n == IDLE);
      if (start_ok) begin
        data_bits <= DataBits;
        pad_bits  <= PadBits;
        cnt       <= 16'd0;
      end else if (xfer) begin
        cnt <= last ? 16'd0 : (cnt + 16'd1);
      end
    end
  end

endmodule
